// File: rtl/irq_prio_pkg.sv
// ----------------------------------------------------------------------------
// irq_prio_pkg
// Shared types and helpers for the rotating-priority interrupt controller.
//   IRQ_N_DEFAULT : default number of interrupt request lines
//   ack_state_t   : acknowledge sequencer states (IDLE, ACK1, ACK2)
//   irq_rank()    : priority rank of an ID for a given lowest-priority ID,
//                   rank 0 is the highest priority
// ----------------------------------------------------------------------------
package irq_prio_pkg;

    localparam int IRQ_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } ack_state_t;

    // rank = (id - lowest_id - 1) mod n_irq, computed without a divider.
    // The biased sum stays in 0 .. 2*n_irq-2, so one conditional subtract
    // is enough to wrap it.
    function automatic int unsigned irq_rank(input int unsigned id,
                                             input int unsigned lowest_id,
                                             input int unsigned n_irq);
        int unsigned d;
        d = id + n_irq - lowest_id - 1;
        if (d >= n_irq) begin
            d = d - n_irq;
        end
        return d;
    endfunction

endpackage

// File: rtl/prio_rot_enc.sv
// ----------------------------------------------------------------------------
// prio_rot_enc
// Combinational rotating priority encoder: returns the set bit of req with
// the best (numerically smallest) rank relative to lowest_id.
// Ports:
//   req       in  N_IRQ  candidate request vector
//   lowest_id in  IDW    ID currently holding the lowest priority
//   found     out 1      at least one bit of req is set
//   best_id   out IDW    ID of the best-ranked set bit (0 when found=0)
// ----------------------------------------------------------------------------
module prio_rot_enc
    import irq_prio_pkg::*;
#(
    parameter int N_IRQ = IRQ_N_DEFAULT,
    parameter int IDW   = $clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] req,
    input  logic [IDW-1:0]   lowest_id,
    output logic             found,
    output logic [IDW-1:0]   best_id
);

    always_comb begin : p_enc
        int unsigned best_rank;
        int unsigned r;
        found     = 1'b0;
        best_id   = '0;
        best_rank = 0;
        r         = 0;
        for (int k = 0; k < N_IRQ; k++) begin
            r = irq_rank(k, 32'(lowest_id), N_IRQ);
            if (req[k] && (!found || (r < best_rank))) begin
                found     = 1'b1;
                best_rank = r;
                best_id   = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/irq_prio_ctrl.sv
// ----------------------------------------------------------------------------
// irq_prio_ctrl
// 8259-style interrupt priority controller with fully nested or automatic
// rotation priority, two-pulse INTA acknowledge and specific/non-specific EOI.
//
// Build option:
//   IRQ_PRIO_EDGE_TRIG_EN  defined   -> IRR bits set on a 0->1 edge of ir
//                          undefined -> level triggered, IRR follows ir
//                                       until the request is acknowledged
//
// Ports:
//   clk          in  1      clock, rising edge
//   rst_n        in  1      asynchronous active-low reset
//   ir           in  N_IRQ  raw interrupt request lines
//   imr          in  N_IRQ  mask, 1 keeps the IRR bit out of arbitration
//   mode_ar      in  1      0 fully nested, 1 automatic rotation
//   eoi          in  1      end-of-interrupt strobe
//   eoi_specific in  1      1 clears isr[eoi_id], 0 clears best-ranked ISR bit
//   eoi_id       in  IDW    target of a specific EOI
//   inta_n       in  1      active-low acknowledge, two pulses per cycle
//   int_req      out 1      interrupt request to the CPU (registered)
//   vec_id       out IDW    acknowledged ID, valid with vec_valid
//   vec_valid    out 1      one-cycle strobe after the second INTA pulse
//   irr          out N_IRQ  interrupt request register
//   isr          out N_IRQ  in-service register
//   spurious     out 1      vec_valid carries a spurious (no winner) vector
// ----------------------------------------------------------------------------
module irq_prio_ctrl
    import irq_prio_pkg::*;
#(
    parameter int N_IRQ = IRQ_N_DEFAULT,
    parameter int IDW   = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] ir,
    input  logic [N_IRQ-1:0] imr,
    input  logic             mode_ar,
    input  logic             eoi,
    input  logic             eoi_specific,
    input  logic [IDW-1:0]   eoi_id,
    input  logic             inta_n,
    output logic             int_req,
    output logic [IDW-1:0]   vec_id,
    output logic             vec_valid,
    output logic [N_IRQ-1:0] irr,
    output logic [N_IRQ-1:0] isr,
    output logic             spurious
);

    localparam logic [N_IRQ-1:0] ONE_HOT0  = N_IRQ'(1);
    localparam logic [IDW-1:0]   ID_LOWEST = IDW'(N_IRQ - 1);

    ack_state_t       state, state_next;
    logic [IDW-1:0]   lowest_id;
    logic             inta_q;
    logic [IDW-1:0]   ack_id;
    logic             ack_spur;

    logic             inta_fall;
    logic             ack_take;
    logic             vec_fire;

    logic             irr_found;
    logic [IDW-1:0]   win_id;
    logic             isr_found;
    logic [IDW-1:0]   isr_best;

    logic [N_IRQ-1:0] ack_set;
    logic [N_IRQ-1:0] eoi_clr;
    logic [IDW-1:0]   eoi_tgt;
    logic             eoi_hit;
    logic [N_IRQ-1:0] irr_next;
    logic             int_req_next;

    // Arbitration always looks at the registers as they stand before this
    // edge, so a coincident EOI cannot influence the acknowledge winner.
    prio_rot_enc #(.N_IRQ(N_IRQ), .IDW(IDW)) u_enc_irr (
        .req       (irr & ~imr),
        .lowest_id (lowest_id),
        .found     (irr_found),
        .best_id   (win_id)
    );

    prio_rot_enc #(.N_IRQ(N_IRQ), .IDW(IDW)) u_enc_isr (
        .req       (isr),
        .lowest_id (lowest_id),
        .found     (isr_found),
        .best_id   (isr_best)
    );

    assign inta_fall = inta_q & ~inta_n;

    // Acknowledge sequencer: next state and one-cycle action strobes
    always_comb begin
        state_next = state;
        ack_take   = 1'b0;
        vec_fire   = 1'b0;
        unique case (state)
            IDLE: begin
                if (inta_fall) begin
                    ack_take   = 1'b1;
                    state_next = ACK1;
                end
            end
            ACK1: begin
                if (inta_fall) begin
                    vec_fire   = 1'b1;
                    state_next = ACK2;
                end
            end
            ACK2: begin
                // Vector is presented during this cycle; further INTA
                // edges are ignored.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign ack_set = (ack_take && irr_found) ? (ONE_HOT0 << win_id) : '0;

    // A specific EOI on a bit that is not in service clears nothing and,
    // through eoi_hit, also leaves the rotation untouched.
    assign eoi_tgt = eoi_specific ? eoi_id : isr_best;
    assign eoi_clr = eoi ? ((ONE_HOT0 << eoi_tgt) & isr) : '0;
    assign eoi_hit = |eoi_clr;

`ifdef IRQ_PRIO_EDGE_TRIG_EN
    logic [N_IRQ-1:0] ir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir;
        end
    end

    // A fresh rising edge on the line being acknowledged re-arms it.
    assign irr_next = (irr & ~ack_set) | (ir & ~ir_q);
`else
    // Level mode: a request withdrawn before acknowledge simply disappears.
    assign irr_next = ir & ~ack_set;
`endif

    always_comb begin
        int unsigned irr_rank;
        int unsigned isr_rank;
        irr_rank     = irq_rank(32'(win_id), 32'(lowest_id), N_IRQ);
        isr_rank     = irq_rank(32'(isr_best), 32'(lowest_id), N_IRQ);
        int_req_next = irr_found && (!isr_found || (irr_rank < isr_rank));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irr       <= '0;
            isr       <= '0;
            int_req   <= 1'b0;
            lowest_id <= ID_LOWEST;
            inta_q    <= 1'b1;
            ack_id    <= '0;
            ack_spur  <= 1'b0;
            vec_id    <= '0;
            vec_valid <= 1'b0;
            spurious  <= 1'b0;
        end else begin
            irr     <= irr_next;
            isr     <= (isr & ~eoi_clr) | ack_set;
            int_req <= int_req_next;
            inta_q  <= inta_n;

            // Fully nested mode pins ID 0 as highest, which also covers
            // dropping out of rotation mode.
            if (!mode_ar) begin
                lowest_id <= ID_LOWEST;
            end else if (eoi_hit) begin
                lowest_id <= eoi_tgt;
            end

            if (ack_take) begin
                ack_id   <= irr_found ? win_id : ID_LOWEST;
                ack_spur <= ~irr_found;
            end

            vec_valid <= vec_fire;
            spurious  <= vec_fire & ack_spur;
            if (vec_fire) begin
                vec_id <= ack_id;
            end
        end
    end

endmodule

// File: tb/tb_irq_prio_ctrl.sv
module tb_irq_prio_ctrl;

    localparam int N_IRQ = 8;
    localparam int IDW   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_IRQ-1:0] ir = '0;
    logic [N_IRQ-1:0] imr = '0;
    logic             mode_ar = 1'b0;
    logic             eoi = 1'b0;
    logic             eoi_specific = 1'b0;
    logic [IDW-1:0]   eoi_id = '0;
    logic             inta_n = 1'b1;
    logic             int_req;
    logic [IDW-1:0]   vec_id;
    logic             vec_valid;
    logic [N_IRQ-1:0] irr;
    logic [N_IRQ-1:0] isr;
    logic             spurious;

    irq_prio_ctrl #(.N_IRQ(N_IRQ), .IDW(IDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir           (ir),
        .imr          (imr),
        .mode_ar      (mode_ar),
        .eoi          (eoi),
        .eoi_specific (eoi_specific),
        .eoi_id       (eoi_id),
        .inta_n       (inta_n),
        .int_req      (int_req),
        .vec_id       (vec_id),
        .vec_valid    (vec_valid),
        .irr          (irr),
        .isr          (isr),
        .spurious     (spurious)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           sp;
    } vec_exp_t;

    vec_exp_t sb_q[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_eoi(input logic spec, input logic [IDW-1:0] id);
        eoi          = 1'b1;
        eoi_specific = spec;
        eoi_id       = id;
        step();
        eoi          = 1'b0;
        eoi_specific = 1'b0;
        eoi_id       = '0;
    endtask

    // Full two-pulse acknowledge. ir_ack is applied together with the first
    // INTA low; eoi_at_ack issues a specific EOI for ID 0 in that same cycle.
    task automatic inta_seq(input logic [N_IRQ-1:0] ir_ack, input logic eoi_at_ack,
                            input logic [IDW-1:0] exp_id, input logic exp_sp);
        vec_exp_t e;
        e.id = exp_id;
        e.sp = exp_sp;
        sb_q.push_back(e);
        ir     = ir_ack;
        inta_n = 1'b0;
        if (eoi_at_ack) begin
            eoi          = 1'b1;
            eoi_specific = 1'b1;
            eoi_id       = '0;
        end
        step();
        eoi          = 1'b0;
        eoi_specific = 1'b0;
        inta_n       = 1'b1;
        step();
        inta_n = 1'b0;
        step();
        inta_n = 1'b1;
        step();
    endtask

    // Scoreboard consumer: every vector strobe must match the oldest entry.
    always @(negedge clk) begin
        if (rst_n && vec_valid) begin
            if (sb_q.size() == 0) begin
                chk("vec_unexpected", 32'(vec_valid), 32'd0);
            end else begin
                vec_exp_t e;
                e = sb_q.pop_front();
                chk("vec_id", 32'(vec_id), 32'(e.id));
                chk("vec_spurious", 32'(spurious), 32'(e.sp));
            end
        end else if (rst_n && spurious) begin
            chk("spurious_stray", 32'(spurious), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irr", 32'(irr), 32'h0);
        chk("rst_isr", 32'(isr), 32'h0);
        chk("rst_int_req", 32'(int_req), 32'h0);
        chk("rst_vec_id", 32'(vec_id), 32'h0);
        chk("rst_vec_valid", 32'(vec_valid), 32'h0);
        chk("rst_spurious", 32'(spurious), 32'h0);
        rst_n = 1'b1;
        step();

        // Fully nested: ID 1 beats ID 5
        ir = 8'h22;
        step();
        step();
        chk("fn_int_req", 32'(int_req), 32'h1);
        chk("fn_irr_pend", 32'(irr), 32'h22);
        inta_seq(8'h20, 1'b0, 3'd1, 1'b0);
        chk("fn_isr", 32'(isr), 32'h02);
        chk("fn_irr", 32'(irr), 32'h20);
        chk("fn_int_req_blocked", 32'(int_req), 32'h0);
        ir = '0;
        step();
        do_eoi(1'b0, '0);
        step();
        chk("fn_isr_eoi", 32'(isr), 32'h00);

        // Nested preemption with ID 1 in service
        ir = 8'h02;
        step();
        step();
        inta_seq(8'h00, 1'b0, 3'd1, 1'b0);
        ir = 8'h01;
        step();
        step();
        chk("nest_hi_int_req", 32'(int_req), 32'h1);
        ir = 8'h00;
        step();
        step();
        ir = 8'h08;
        step();
        step();
        chk("nest_lo_int_req", 32'(int_req), 32'h0);
        chk("nest_lo_irr", 32'(irr), 32'h08);
        ir = 8'h00;
        step();
        do_eoi(1'b0, '0);
        step();

        // Automatic rotation
        mode_ar = 1'b1;
        ir = 8'h04;
        step();
        step();
        inta_seq(8'h00, 1'b0, 3'd2, 1'b0);
        do_eoi(1'b0, '0);
        ir = 8'h0C;
        step();
        step();
        chk("rot_int_req", 32'(int_req), 32'h1);
        inta_seq(8'h00, 1'b0, 3'd3, 1'b0);
        chk("rot_isr", 32'(isr), 32'h08);
        do_eoi(1'b0, '0);
        chk("rot_isr_eoi", 32'(isr), 32'h00);
        // Leaving rotation restores ID 0 as highest (ID 4 would win if the
        // rotated order with lowest_id=3 were still in effect).
        ir = 8'h11;
        mode_ar = 1'b0;
        step();
        step();
        inta_seq(8'h00, 1'b0, 3'd0, 1'b0);
        chk("fn_restore_isr", 32'(isr), 32'h01);
        do_eoi(1'b1, 3'd0);
        chk("spec_eoi_isr", 32'(isr), 32'h00);

        // Spurious: request withdrawn before the first INTA edge
        ir = 8'h01;
        step();
        step();
        chk("spur_int_req", 32'(int_req), 32'h1);
        ir = 8'h00;
        step();
        inta_seq(8'h00, 1'b0, 3'd7, 1'b1);
        chk("spur_isr", 32'(isr), 32'h00);
        chk("spur_irr", 32'(irr), 32'h00);

        // Masked line keeps its IRR bit and loses arbitration
        imr = 8'h01;
        ir = 8'h03;
        step();
        step();
        inta_seq(8'h01, 1'b0, 3'd1, 1'b0);
        chk("mask_irr", 32'(irr), 32'h01);
        chk("mask_isr", 32'(isr), 32'h02);
        ir = 8'h00;
        imr = 8'h00;
        step();
        do_eoi(1'b0, '0);
        step();

        // EOI coincident with the first INTA edge
        ir = 8'h01;
        step();
        step();
        inta_seq(8'h00, 1'b0, 3'd0, 1'b0);
        ir = 8'h10;
        step();
        step();
        chk("coinc_int_req", 32'(int_req), 32'h0);
        inta_seq(8'h00, 1'b1, 3'd4, 1'b0);
        chk("coinc_isr", 32'(isr), 32'h10);
        do_eoi(1'b0, '0);
        step();

        // Reset between the two INTA pulses
        ir = 8'h04;
        step();
        step();
        inta_n = 1'b0;
        step();
        inta_n = 1'b1;
        step();
        chk("mid_isr_pre", 32'(isr), 32'h04);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_irr", 32'(irr), 32'h0);
        chk("mid_rst_isr", 32'(isr), 32'h0);
        chk("mid_rst_int_req", 32'(int_req), 32'h0);
        chk("mid_rst_vec_id", 32'(vec_id), 32'h0);
        chk("mid_rst_vec_valid", 32'(vec_valid), 32'h0);
        chk("mid_rst_spurious", 32'(spurious), 32'h0);
        ir = 8'h00;
        step();
        rst_n = 1'b1;
        step();
        inta_n = 1'b0;
        step();
        inta_n = 1'b1;
        step();
        step();
        chk("mid_no_vec_valid", 32'(vec_valid), 32'h0);
        chk("mid_isr_post", 32'(isr), 32'h0);
        step();
        step();

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_prio_ctrl.md
IRQ_PRIO_CTRL -- requirements
Module: irq_prio_ctrl

Interface
REQ-001 Parameter N_IRQ, default 8, number of interrupt request lines, legal range 2..32.
REQ-002 Parameter IDW, default $clog2(N_IRQ), width of an interrupt ID.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ir  input  N_IRQ  raw interrupt request lines, synchronous to clk.
REQ-006 imr  input  N_IRQ  mask; bit=1 blocks the corresponding IRR bit from arbitration.
REQ-007 mode_ar  input  1  0 = fully nested, 1 = automatic rotation.
REQ-008 eoi  input  1  one-cycle end-of-interrupt strobe.
REQ-009 eoi_specific  input  1  qualifies eoi: 1 = clear ISR[eoi_id], 0 = clear the highest-priority ISR bit.
REQ-010 eoi_id  input  IDW  target ID for specific EOI.
REQ-011 inta_n  input  1  active-low acknowledge, synchronous to clk, two pulses per acknowledge cycle.
REQ-012 int_req  output  1  interrupt request to the CPU.
REQ-013 vec_id  output  IDW  acknowledged ID; valid only while vec_valid=1.
REQ-014 vec_valid  output  1  one-cycle strobe.
REQ-015 irr  output  N_IRQ  interrupt request register.
REQ-016 isr  output  N_IRQ  in-service register.
REQ-017 spurious  output  1  one-cycle strobe accompanying vec_valid when no request won at the first INTA.

Function
REQ-018 Priority is rotating:
- lowest_id register; priority rank of ID k = (k - lowest_id - 1) mod N_IRQ, rank 0 highest.
- Fully nested mode holds lowest_id = N_IRQ-1, so ID 0 is highest.
REQ-019 IRR bit k sets on an active ir[k] sample and clears only when that ID is acknowledged; IRR bits are never cleared by imr.
REQ-020 int_req is registered, one cycle after the inputs: 1 iff (irr & ~imr) is nonzero and its best-ranked bit strictly outranks the best-ranked ISR bit (or isr is 0).
REQ-021 Falling edges of inta_n are detected from a registered copy of inta_n.
REQ-022 Acknowledge FSM states are IDLE, ACK1 and ACK2.
REQ-023 IDLE -> ACK1 on the first falling edge; in that same edge's update:
- winner W = best-ranked bit of irr & ~imr;
- isr[W] set, irr[W] cleared, W latched.
REQ-024 If no winner exists at the first falling edge:
- no ISR/IRR change;
- latched ID = N_IRQ-1;
- spurious flag latched.
REQ-025 ACK1 -> ACK2 on the second falling edge; in the following cycle vec_valid=1, vec_id = latched ID, spurious = latched flag; ACK2 -> IDLE unconditionally after that one cycle.
REQ-026 Non-specific EOI clears the best-ranked ISR bit; specific EOI clears isr[eoi_id]; EOI with the target bit already 0 changes nothing.
REQ-027 Rotation on EOI:
- With mode_ar=1 and an EOI that clears bit B, lowest_id <= B.
- With mode_ar=0, lowest_id is unchanged.
REQ-028 EOI and the first falling edge in the same cycle: next isr = (isr & ~eoi_clear) | ack_set; arbitration uses pre-update registers.
REQ-029 inta_n falling edges while in ACK2 are ignored.
REQ-030 mode_ar 1->0 forces lowest_id to N_IRQ-1 on the next edge.

Reset
REQ-031 Asynchronous reset on rst_n low, all registers cleared:
- irr=0, isr=0, int_req=0, vec_id=0, vec_valid=0, spurious=0;
- lowest_id=N_IRQ-1, FSM=IDLE, registered inta_n=1.
REQ-032 Reset mid-acknowledge abandons the cycle; no vec_valid is issued after release.

Configuration
REQ-033 Macro IRQ_PRIO_EDGE_TRIG_EN.
- Defined: irr[k] sets only on a 0->1 transition of ir[k]; a registered copy of ir is kept.
- Undefined: level-triggered; irr[k] sets whenever ir[k]=1 and additionally clears when ir[k]=0 before acknowledge.

Structure
REQ-034 Package irq_prio_pkg holds the FSM state enum, the default N_IRQ constant and an rank function (ID, lowest_id -> rank).
REQ-035 Combinational sub-module prio_rot_enc(N_IRQ) returns the best-ranked set bit and a found flag; instantiated twice, once for masked IRR and once for ISR.

Verification
REQ-036 Fully nested: ir=0x22, imr=0 -> int_req=1; two INTA pulses -> vec_id=1, isr=0x02, irr=0x20.
REQ-037 Nested preemption: with isr=0x02, ir[0] asserted -> int_req=1; ir[3] alone asserted -> int_req=0.
REQ-038 Rotation: mode_ar=1, service ID 2, non-specific EOI -> lowest_id=2; then ir=0x0C -> vec_id=3 wins over ID 2.
REQ-039 Spurious: ir pulse withdrawn before the first INTA (level mode) -> vec_id=7, spurious=1, isr unchanged.
REQ-040 EOI coincident with the first INTA edge: isr=0x01, specific eoi_id=0, pending ID 4 -> isr=0x10 afterwards.
REQ-041 rst_n pulsed low between INTA pulses -> all outputs 0, no vec_valid after the second pulse.
